// File: rtl/bus_reg_bank.sv
// bus_reg_bank
//    Bank of up to 16 bus-accessible registers on the FPGA bus. Each register
//    is one of four kinds: read/write, read-only, a self-clearing pulse, or a
//    sticky write-1-to-clear status. The block also produces a write strobe per
//    register and an interrupt built from the sticky status bits.
//
// Parameters
//    BUS_WIDTH   data width (8, 16 or 32); registers sit on BUS_WIDTH/8 byte strides
//    NUM_REGS    number of registers, 1..16
//    INIT        flattened reset values, register n at [n*BUS_WIDTH +: BUS_WIDTH]
//                (only read/write registers use it)
//    RO_MASK     bit n set: register n is read-only
//    W1C_MASK    bit n set: register n is sticky write-1-to-clear
//    PULSE_MASK  bit n set: register n clears itself one cycle after a write
//    If several mask bits are set for one register: RO > W1C > PULSE > RW.
//
// Ports
//    i_Bus_Clk      bus clock; all state changes on its rising edge
//    i_Bus_Rst      synchronous active-high reset
//    i_Bus_CS       chip select; one transaction per cycle while high
//    i_Bus_Wr_Rd_n  1 = write, 0 = read
//    i_Bus_Addr8    byte address
//    i_Bus_Wr_Data  write data
//    o_Bus_Rd_Data  read data; holds until the next read
//    o_Bus_Rd_DV    read data valid, one cycle per read
//    i_Reg          read-only values, or set bits for W1C registers
//    o_Reg          register contents (read-only slices are 0)
//    o_Reg_Wr_Stb   one-cycle write strobe per register
//    o_Irq          registered OR of all W1C register bits

module bus_reg_bank #(
   parameter int                             BUS_WIDTH  = 16,
   parameter int                             NUM_REGS   = 4,
   parameter logic [NUM_REGS*BUS_WIDTH-1:0]  INIT       = '0,
   parameter logic [15:0]                    RO_MASK    = 16'h0000,
   parameter logic [15:0]                    W1C_MASK   = 16'h0000,
   parameter logic [15:0]                    PULSE_MASK = 16'h0000
) (
   input  logic                            i_Bus_Clk,
   input  logic                            i_Bus_Rst,
   input  logic                            i_Bus_CS,
   input  logic                            i_Bus_Wr_Rd_n,
   input  logic [7:0]                      i_Bus_Addr8,
   input  logic [BUS_WIDTH-1:0]            i_Bus_Wr_Data,
   output logic [BUS_WIDTH-1:0]            o_Bus_Rd_Data,
   output logic                            o_Bus_Rd_DV,
   input  logic [NUM_REGS*BUS_WIDTH-1:0]   i_Reg,
   output logic [NUM_REGS*BUS_WIDTH-1:0]   o_Reg,
   output logic [NUM_REGS-1:0]             o_Reg_Wr_Stb,
   output logic                            o_Irq
);

   localparam int BYTES = BUS_WIDTH / 8;
   localparam int SHIFT = $clog2(BYTES);

   // Resolve the mode masks once so each register has exactly one kind.
   localparam logic [15:0] RO_M    = RO_MASK;
   localparam logic [15:0] W1C_M   = W1C_MASK & ~RO_MASK;
   localparam logic [15:0] PULSE_M = PULSE_MASK & ~RO_MASK & ~W1C_MASK;
   localparam logic [15:0] RW_M    = ~(RO_M | W1C_M | PULSE_M);

   logic [BUS_WIDTH-1:0] reg_q [NUM_REGS];
   logic [7:0]           idx;
   logic                 idx_valid;
   logic [NUM_REGS-1:0]  wr_hit;
   logic                 rd_hit;
   logic [BUS_WIDTH-1:0] rd_mux;
   logic                 irq_next;

   // Address decode: the byte-lane bits are dropped, so every byte address
   // inside a register's stride selects that register.
   always_comb begin
      idx       = i_Bus_Addr8 >> SHIFT;
      idx_valid = (idx < 8'(NUM_REGS));
      rd_hit    = i_Bus_CS & ~i_Bus_Wr_Rd_n;
      wr_hit    = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         wr_hit[n] = i_Bus_CS & i_Bus_Wr_Rd_n & idx_valid & (idx == 8'(n));
      end
   end

   // Read mux: read-only registers show their live input, everything else
   // shows the stored value. An out-of-range index matches nothing and reads 0.
   always_comb begin
      rd_mux = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (idx == 8'(n)) begin
            rd_mux = RO_M[n] ? i_Reg[n*BUS_WIDTH +: BUS_WIDTH] : reg_q[n];
         end
      end
   end

   // The interrupt is the OR of the sticky bits as they stand now; it is
   // registered below, so it trails the status registers by one cycle.
   always_comb begin
      irq_next = 1'b0;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (W1C_M[n]) begin
            irq_next = irq_next | (|reg_q[n]);
         end
      end
   end

   // Register storage. W1C registers update every cycle so set inputs are
   // captured even without bus activity; the set term is OR-ed in after the
   // clear so a simultaneous set wins. Pulse registers fall back to 0
   // whenever they are not being written.
   always_ff @(posedge i_Bus_Clk) begin
      if (i_Bus_Rst) begin
         for (int n = 0; n < NUM_REGS; n++) begin
            reg_q[n] <= RW_M[n] ? INIT[n*BUS_WIDTH +: BUS_WIDTH] : '0;
         end
      end else begin
         for (int n = 0; n < NUM_REGS; n++) begin
            if (RO_M[n]) begin
               reg_q[n] <= '0;
            end else if (W1C_M[n]) begin
               reg_q[n] <= (reg_q[n] & ~(wr_hit[n] ? i_Bus_Wr_Data : '0))
                           | i_Reg[n*BUS_WIDTH +: BUS_WIDTH];
            end else if (PULSE_M[n]) begin
               reg_q[n] <= wr_hit[n] ? i_Bus_Wr_Data : '0;
            end else if (wr_hit[n]) begin
               reg_q[n] <= i_Bus_Wr_Data;
            end
         end
      end
   end

   // Bus-side outputs: strobes, read response and the interrupt. Read data
   // only changes on a read so it stays stable between reads.
   always_ff @(posedge i_Bus_Clk) begin
      if (i_Bus_Rst) begin
         o_Reg_Wr_Stb  <= '0;
         o_Bus_Rd_DV   <= 1'b0;
         o_Bus_Rd_Data <= '0;
         o_Irq         <= 1'b0;
      end else begin
         o_Reg_Wr_Stb <= wr_hit;
         o_Bus_Rd_DV  <= rd_hit;
         o_Irq        <= irq_next;
         if (rd_hit) begin
            o_Bus_Rd_Data <= rd_mux;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign o_Reg[g*BUS_WIDTH +: BUS_WIDTH] = reg_q[g];
   end

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank
//    Directed bench for bus_reg_bank in a four-register configuration:
//    reg0 RW @0x00 (reset 0x1234), reg1 PULSE @0x02, reg2 RO @0x04,
//    reg3 W1C @0x06. Inputs change 1 ns after a rising edge and outputs are
//    checked 1 ns after the next rising edge.

module tb_bus_reg_bank;

   localparam int BW = 16;
   localparam int NR = 4;

   logic          clock;
   logic          rst;
   logic          cs;
   logic          wr;
   logic [7:0]    addr;
   logic [BW-1:0] wdata;
   logic [BW-1:0] rdData;
   logic          rdDv;
   logic [NR*BW-1:0] regIn;
   logic [NR*BW-1:0] regOut;
   logic [NR-1:0] stb;
   logic          irq;

   int total = 0;
   int bad   = 0;

   bus_reg_bank #(
      .BUS_WIDTH (BW),
      .NUM_REGS  (NR),
      .INIT      (64'h0000_0000_0000_1234),
      .RO_MASK   (16'b0100),
      .W1C_MASK  (16'b1000),
      .PULSE_MASK(16'b0010)
   ) dut (
      .i_Bus_Clk    (clock),
      .i_Bus_Rst    (rst),
      .i_Bus_CS     (cs),
      .i_Bus_Wr_Rd_n(wr),
      .i_Bus_Addr8  (addr),
      .i_Bus_Wr_Data(wdata),
      .o_Bus_Rd_Data(rdData),
      .o_Bus_Rd_DV  (rdDv),
      .i_Reg        (regIn),
      .o_Reg        (regOut),
      .o_Reg_Wr_Stb (stb),
      .o_Irq        (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Set bus inputs for the next edge.
   task automatic applyStimulus(input logic c, input logic w, input logic [7:0] a,
                                input logic [BW-1:0] d);
      cs    = c;
      wr    = w;
      addr  = a;
      wdata = d;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst   = 1'b1;
      regIn = '0;
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("rst_dv",    32'(rdDv),   32'h0);
      checkOutput("rst_data",  32'(rdData), 32'h0);
      checkOutput("rst_stb",   32'(stb),    32'h0);
      checkOutput("rst_irq",   32'(irq),    32'h0);
      checkOutput("rst_reg0",  32'(regOut[15:0]),  32'h1234);
      checkOutput("rst_reg1",  32'(regOut[31:16]), 32'h0);
      checkOutput("rst_reg2",  32'(regOut[47:32]), 32'h0);
      checkOutput("rst_reg3",  32'(regOut[63:48]), 32'h0);

      // Read reset value of reg0
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("rd0_dv",   32'(rdDv),   32'h1);
      checkOutput("rd0_data", 32'(rdData), 32'h1234);
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("rd0_dv_drop", 32'(rdDv),   32'h0);
      checkOutput("rd0_hold",    32'(rdData), 32'h1234);

      // RW write, then read through the odd byte address
      applyStimulus(1'b1, 1'b1, 8'h00, 16'hBEEF);
      tick();
      checkOutput("wr0_reg", 32'(regOut[15:0]), 32'hBEEF);
      checkOutput("wr0_stb", 32'(stb),          32'h1);
      checkOutput("wr0_nodv", 32'(rdDv),        32'h0);
      applyStimulus(1'b1, 1'b0, 8'h01, 16'h0000);
      tick();
      checkOutput("rd1_stb",  32'(stb),    32'h0);
      checkOutput("rd1_dv",   32'(rdDv),   32'h1);
      checkOutput("rd1_data", 32'(rdData), 32'hBEEF);

      // Pulse register
      applyStimulus(1'b1, 1'b1, 8'h02, 16'h00A5);
      tick();
      checkOutput("pls_reg", 32'(regOut[31:16]), 32'h00A5);
      checkOutput("pls_stb", 32'(stb),           32'h2);
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("pls_clr",   32'(regOut[31:16]), 32'h0);
      checkOutput("pls_nostb", 32'(stb),           32'h0);
      applyStimulus(1'b1, 1'b1, 8'h02, 16'h0001);
      tick();
      checkOutput("pls_b2b1", 32'(regOut[31:16]), 32'h0001);
      applyStimulus(1'b1, 1'b1, 8'h02, 16'h0002);
      tick();
      checkOutput("pls_b2b2", 32'(regOut[31:16]), 32'h0002);
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("pls_b2b0", 32'(regOut[31:16]), 32'h0);

      // Read-only register; non-W1C slices of i_Reg must not leak into o_Reg
      regIn = 64'h0000_5A5A_FFFF_FFFF;
      applyStimulus(1'b1, 1'b0, 8'h04, 16'h0000);
      tick();
      checkOutput("ro_dv",    32'(rdDv),   32'h1);
      checkOutput("ro_data",  32'(rdData), 32'h5A5A);
      checkOutput("ro_reg0",  32'(regOut[15:0]),  32'hBEEF);
      checkOutput("ro_reg1",  32'(regOut[31:16]), 32'h0);
      applyStimulus(1'b1, 1'b1, 8'h04, 16'hFFFF);
      tick();
      checkOutput("ro_stb",   32'(stb),           32'h4);
      checkOutput("ro_reg2",  32'(regOut[47:32]), 32'h0);
      regIn = '0;

      // Sticky status register and interrupt
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      regIn[63:48] = 16'h0009;
      tick();
      checkOutput("w1c_set",   32'(regOut[63:48]), 32'h0009);
      checkOutput("w1c_irq0",  32'(irq),           32'h0);
      regIn[63:48] = 16'h0000;
      tick();
      checkOutput("w1c_hold",  32'(regOut[63:48]), 32'h0009);
      checkOutput("w1c_irq1",  32'(irq),           32'h1);
      regIn[63:48] = 16'h0001;
      applyStimulus(1'b1, 1'b1, 8'h06, 16'h0001);
      tick();
      checkOutput("w1c_setwin", 32'(regOut[63:48]), 32'h0009);
      checkOutput("w1c_stb",    32'(stb),           32'h8);
      regIn[63:48] = 16'h0000;
      applyStimulus(1'b1, 1'b1, 8'h06, 16'h0009);
      tick();
      checkOutput("w1c_clr",     32'(regOut[63:48]), 32'h0);
      checkOutput("w1c_irqlag",  32'(irq),           32'h1);
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("w1c_irqdrop", 32'(irq),           32'h0);

      // Out-of-range accesses
      applyStimulus(1'b1, 1'b0, 8'h08, 16'h0000);
      tick();
      checkOutput("oor_rd_dv",   32'(rdDv),   32'h1);
      checkOutput("oor_rd_data", 32'(rdData), 32'h0);
      applyStimulus(1'b1, 1'b1, 8'h08, 16'h5555);
      tick();
      checkOutput("oor_wr_stb",  32'(stb),    32'h0);
      checkOutput("oor_wr_regs", 32'(regOut), 32'h0000BEEF);
      checkOutput("oor_wr_hi",   32'(regOut[63:32]), 32'h0);

      // Reset during a read
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("rstrd_dv",   32'(rdDv),          32'h0);
      checkOutput("rstrd_reg0", 32'(regOut[15:0]),  32'h1234);
      checkOutput("rstrd_data", 32'(rdData),        32'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
      tick();
      checkOutput("rstrd_dv2",  32'(rdDv),          32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_reg_bank.md
# bus_reg_bank

Parametrised bank of up to 16 bus-accessible registers on the 16-bit FPGA bus, with selectable per-register behaviour: read/write, read-only, self-clearing pulse, and write-1-to-clear sticky status. The block also provides per-register write strobes and an interrupt output. It sits behind the bus address decoder and drives control and status fields of user logic.

## Interface
- BUS_WIDTH, 16: data width; 8, 16 or 32. BYTES = BUS_WIDTH/8.
- NUM_REGS, 4: number of registers, 1..16.
- INIT, 0: flattened NUM_REGS*BUS_WIDTH reset values; register n is slice [n*BUS_WIDTH +: BUS_WIDTH]. Used by RW registers only.
- RO_MASK, 0: bit n=1 makes register n read-only.
- W1C_MASK, 0: bit n=1 makes register n a sticky write-1-to-clear status register.
- PULSE_MASK, 0: bit n=1 makes register n self-clearing after one cycle.
- Mode priority: RO > W1C > PULSE > RW (default).

Ports:
- i_Bus_Clk  in  1  bus clock; everything is clocked on its rising edge.
- i_Bus_Rst  in  1  reset; synchronous, active-high.
- i_Bus_CS  in  1  chip select; one transaction per cycle while high.
- i_Bus_Wr_Rd_n  in  1  1 = write, 0 = read.
- i_Bus_Addr8  in  8  byte address.
- i_Bus_Wr_Data  in  BUS_WIDTH  write data.
- o_Bus_Rd_Data  out  BUS_WIDTH  read data.
- o_Bus_Rd_DV  out  1  read data valid; one-cycle pulse.
- i_Reg  in  NUM_REGS*BUS_WIDTH  RO read values, or W1C set-bit inputs.
- o_Reg  out  NUM_REGS*BUS_WIDTH  register contents.
- o_Reg_Wr_Stb  out  NUM_REGS  one-cycle write strobe per register.
- o_Irq  out  1  OR of all W1C register bits, registered.

## Operation
- Index: idx = i_Bus_Addr8 >> log2(BYTES). Byte-lane bits are ignored.
- Out of range (idx >= NUM_REGS):
  - Write is dropped; no strobe.
  - Read returns 0 with DV.
- Write (CS=1, Wr_Rd_n=1, idx valid):
  - o_Reg_Wr_Stb[idx] pulses for all modes, including RO.
  - RW: o_Reg slice <= Wr_Data.
  - RO: no storage; write has no effect. o_Reg slice is constant 0.
  - PULSE: o_Reg slice <= Wr_Data for exactly one cycle, then 0.
    - Back-to-back writes hold each new value for one cycle each.
  - W1C: bits where Wr_Data=1 clear.
- W1C set path, every cycle, CS or not:
  - o_Reg slice <= (o_Reg & ~clr) | i_Reg slice, where clr = Wr_Data on a write to that register, else 0.
  - Set wins over a simultaneous clear.
  - Non-W1C registers ignore their i_Reg slice, except RO.
- Read (CS=1, Wr_Rd_n=0):
  - RO returns the i_Reg slice.
  - RW, PULSE and W1C return the current o_Reg slice, sampled before that edge's update.
- o_Irq <= |(o_Reg bits of all W1C registers). It is 0 if W1C_MASK = 0.

## Timing
- Reset values, applied at the first rising edge with i_Bus_Rst=1:
  - o_Bus_Rd_Data 0, o_Bus_Rd_DV 0, o_Reg_Wr_Stb 0, o_Irq 0.
  - o_Reg: RW = INIT; RO, PULSE, W1C = 0.
- Reset overrides any concurrent bus transaction or i_Reg set. A read issued in the reset cycle produces no DV.
- Write latency: the o_Reg change and o_Reg_Wr_Stb are visible after the edge that samples CS.
- Read latency: o_Bus_Rd_DV and o_Bus_Rd_Data are valid after the edge that samples CS.
  - DV is high exactly one cycle per read.
  - Rd_Data holds its value until the next read.
  - Back-to-back reads give DV on consecutive cycles.
- W1C: i_Reg bit high at edge k sets o_Reg after edge k; o_Irq rises after edge k+1.
  - Clearing the last set bit at edge k drops o_Irq after edge k+1.
- No handshake or backpressure: every CS cycle is accepted.

## Test plan
Common configuration: BUS_WIDTH=16, NUM_REGS=4, INIT reg0=0x1234, PULSE_MASK=0b0010, RO_MASK=0b0100, W1C_MASK=0b1000. This gives reg0 RW @0x00, reg1 PULSE @0x02, reg2 RO @0x04, reg3 W1C @0x06.

- Reset, then read 0x00 → DV one cycle later with data 0x1234; o_Reg of regs 1–3 = 0; o_Irq=0.
- Write 0xBEEF to 0x00, then read 0x01 → o_Reg0=0xBEEF and Stb[0] pulses one cycle; the read returns 0xBEEF (lane bit ignored).
- Write 0x00A5 to 0x02 → o_Reg1=0x00A5 for one cycle, then 0; Stb[1] pulses. Two consecutive writes 0x1/0x2 → 0x1, 0x2, then 0.
- i_Reg2=0x5A5A, read 0x04 → returns 0x5A5A. Write 0xFFFF to 0x04 → Stb[2] pulses; o_Reg2 stays 0.
- Pulse i_Reg3 bit0 and bit3 for one cycle → o_Reg3=0x0009; o_Irq rises one cycle later. Write 0x0001 while i_Reg3 bit0 is held high → stays 0x0009 (set wins). Release, write 0x0009 → 0; o_Irq drops one cycle later.
- Read 0x08 → DV with data 0. Write 0x08 → no strobe and no change. Assert reset mid-read → DV never asserts; o_Reg0 returns to 0x1234.
